id_ex_reg: RTL and testbench

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg.sv | 95 +++++++++
 tb/tb_id_ex_reg.sv | 135 +++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with stall hold, flush bubbles and a saturating bubble counter
module id_ex_reg (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        valid_i,
    input  logic        RegDst_i,
    input  logic        ALUSrc_i,
    input  logic        MemtoReg_i,
    input  logic        RegWrite_i,
    input  logic        MemWrite_i,
    input  logic        MemRead_i,
    input  logic [1:0]  ALUOp_i,
    input  logic [31:0] RS_data_i,
    input  logic [31:0] RT_data_i,
    input  logic [15:0] imm_i,
    input  logic        ExtOp_i,
    input  logic [5:0]  funct_i,
    input  logic [4:0]  RS_addr_i,
    input  logic [4:0]  RT_addr_i,
    input  logic [4:0]  RD_addr_i,
    output logic        valid_o,
    output logic        RegDst_o,
    output logic        ALUSrc_o,
    output logic        MemtoReg_o,
    output logic        RegWrite_o,
    output logic        MemWrite_o,
    output logic        MemRead_o,
    output logic [1:0]  ALUOp_o,
    output logic [31:0] RS_data_o,
    output logic [31:0] RT_data_o,
    output logic [31:0] imm_o,
    output logic [5:0]  funct_o,
    output logic [4:0]  RS_addr_o,
    output logic [4:0]  RT_addr_o,
    output logic [4:0]  WriteReg_o,
    output logic [15:0] bubble_cnt_o
);

    logic [31:0] imm_ext;
    logic [4:0]  write_reg;

    // extend the immediate and resolve the destination register before latching
    always_comb begin
        imm_ext   = ExtOp_i ? {{16{imm_i[15]}}, imm_i} : {16'b0, imm_i};
        write_reg = RegDst_i ? RD_addr_i : RT_addr_i;
    end

    // pipeline slot: flush clears to a bubble, stall holds, otherwise load; invalid slots never write
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i || flush_i) begin
            valid_o    <= 1'b0;
            RegDst_o   <= 1'b0;
            ALUSrc_o   <= 1'b0;
            MemtoReg_o <= 1'b0;
            RegWrite_o <= 1'b0;
            MemWrite_o <= 1'b0;
            MemRead_o  <= 1'b0;
            ALUOp_o    <= 2'd0;
            RS_data_o  <= 32'd0;
            RT_data_o  <= 32'd0;
            imm_o      <= 32'd0;
            funct_o    <= 6'd0;
            RS_addr_o  <= 5'd0;
            RT_addr_o  <= 5'd0;
            WriteReg_o <= 5'd0;
        end else if (!stall_i) begin
            valid_o    <= valid_i;
            RegDst_o   <= RegDst_i;
            ALUSrc_o   <= ALUSrc_i;
            MemtoReg_o <= MemtoReg_i;
            RegWrite_o <= RegWrite_i & valid_i;
            MemWrite_o <= MemWrite_i & valid_i;
            MemRead_o  <= MemRead_i & valid_i;
            ALUOp_o    <= ALUOp_i;
            RS_data_o  <= RS_data_i;
            RT_data_o  <= RT_data_i;
            imm_o      <= imm_ext;
            funct_o    <= funct_i;
            RS_addr_o  <= RS_addr_i;
            RT_addr_o  <= RT_addr_i;
            WriteReg_o <= write_reg;
        end
    end

    // count every flush, stalled or not, saturating at all-ones
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            bubble_cnt_o <= 16'd0;
        else if (flush_i && bubble_cnt_o != 16'hFFFF)
            bubble_cnt_o <= bubble_cnt_o + 16'd1;
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: directed self-checking bench for the ID/EX pipeline register
module tb_id_ex_reg;

    logic        clk_i = 1'b0, rst_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0, valid_i = 1'b0;
    logic        RegDst_i = 1'b0, ALUSrc_i = 1'b0, MemtoReg_i = 1'b0;
    logic        RegWrite_i = 1'b0, MemWrite_i = 1'b0, MemRead_i = 1'b0;
    logic [1:0]  ALUOp_i = 2'd0;
    logic [31:0] RS_data_i = 32'd0, RT_data_i = 32'd0;
    logic [15:0] imm_i = 16'd0;
    logic        ExtOp_i = 1'b0;
    logic [5:0]  funct_i = 6'd0;
    logic [4:0]  RS_addr_i = 5'd0, RT_addr_i = 5'd0, RD_addr_i = 5'd0;
    logic        valid_o, RegDst_o, ALUSrc_o, MemtoReg_o, RegWrite_o, MemWrite_o, MemRead_o;
    logic [1:0]  ALUOp_o;
    logic [31:0] RS_data_o, RT_data_o, imm_o;
    logic [5:0]  funct_o;
    logic [4:0]  RS_addr_o, RT_addr_o, WriteReg_o;
    logic [15:0] bubble_cnt_o;
    int checks = 0, errors = 0;

    id_ex_reg dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
        .RegDst_i(RegDst_i), .ALUSrc_i(ALUSrc_i), .MemtoReg_i(MemtoReg_i),
        .RegWrite_i(RegWrite_i), .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i),
        .ALUOp_i(ALUOp_i), .RS_data_i(RS_data_i), .RT_data_i(RT_data_i), .imm_i(imm_i),
        .ExtOp_i(ExtOp_i), .funct_i(funct_i), .RS_addr_i(RS_addr_i), .RT_addr_i(RT_addr_i),
        .RD_addr_i(RD_addr_i), .valid_o(valid_o), .RegDst_o(RegDst_o), .ALUSrc_o(ALUSrc_o),
        .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o), .MemWrite_o(MemWrite_o),
        .MemRead_o(MemRead_o), .ALUOp_o(ALUOp_o), .RS_data_o(RS_data_o), .RT_data_o(RT_data_o),
        .imm_o(imm_o), .funct_o(funct_o), .RS_addr_o(RS_addr_o), .RT_addr_o(RT_addr_o),
        .WriteReg_o(WriteReg_o), .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // OR of every output so a single compare proves the whole register is clear
    function automatic logic [31:0] all_or();
        return {31'd0, valid_o | RegDst_o | ALUSrc_o | MemtoReg_o | RegWrite_o | MemWrite_o | MemRead_o}
             | {30'd0, ALUOp_o} | RS_data_o | RT_data_o | imm_o | {26'd0, funct_o}
             | {27'd0, RS_addr_o} | {27'd0, RT_addr_o} | {27'd0, WriteReg_o} | {16'd0, bubble_cnt_o};
    endfunction

    initial begin
        #3;
        chk("reset_all_zero", all_or(), 32'd0);
        chk("reset_valid", {31'd0, valid_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        valid_i = 1'b1; RegWrite_i = 1'b1; RegDst_i = 1'b1; RD_addr_i = 5'd9; RT_addr_i = 5'd3;
        imm_i = 16'h8001; ExtOp_i = 1'b1; ALUOp_i = 2'd3; funct_i = 6'h2a;
        RS_data_i = 32'h1234; RT_data_i = 32'h5678; RS_addr_i = 5'd7; ALUSrc_i = 1'b1;
        step();
        chk("load_writereg_rd", {27'd0, WriteReg_o}, 32'd9);
        chk("load_imm_sext", imm_o, 32'hFFFF8001);
        chk("load_valid", {31'd0, valid_o}, 32'd1);
        chk("load_regwrite", {31'd0, RegWrite_o}, 32'd1);
        chk("load_aluop3", {30'd0, ALUOp_o}, 32'd3);
        chk("load_rs_data", RS_data_o, 32'h1234);
        chk("load_rt_data", RT_data_o, 32'h5678);
        chk("load_funct", {26'd0, funct_o}, 32'h2a);
        chk("load_rs_addr", {27'd0, RS_addr_o}, 32'd7);
        chk("load_alusrc", {31'd0, ALUSrc_o}, 32'd1);
        ExtOp_i = 1'b0; RegDst_i = 1'b0;
        step();
        chk("load_imm_zext", imm_o, 32'h00008001);
        chk("load_writereg_rt", {27'd0, WriteReg_o}, 32'd3);
        stall_i = 1'b1; RS_data_i = 32'hDEAD; RegDst_i = 1'b1; imm_i = 16'h0042;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_rs_hold", RS_data_o, 32'h1234);
            chk("stall_cnt_hold", {16'd0, bubble_cnt_o}, 32'd0);
        end
        chk("stall_writereg_hold", {27'd0, WriteReg_o}, 32'd3);
        chk("stall_imm_hold", imm_o, 32'h00008001);
        flush_i = 1'b1; MemWrite_i = 1'b1;
        step();
        chk("flushstall_memwrite", {31'd0, MemWrite_o}, 32'd0);
        chk("flushstall_valid", {31'd0, valid_o}, 32'd0);
        chk("flushstall_cnt", {16'd0, bubble_cnt_o}, 32'd1);
        chk("flushstall_rs", RS_data_o, 32'd0);
        chk("flushstall_writereg", {27'd0, WriteReg_o}, 32'd0);
        flush_i = 1'b0; stall_i = 1'b0; valid_i = 1'b0; MemRead_i = 1'b1; RS_data_i = 32'hCAFE;
        RegDst_i = 1'b0;
        step();
        chk("invalid_regwrite", {31'd0, RegWrite_o}, 32'd0);
        chk("invalid_memread", {31'd0, MemRead_o}, 32'd0);
        chk("invalid_memwrite", {31'd0, MemWrite_o}, 32'd0);
        chk("invalid_valid", {31'd0, valid_o}, 32'd0);
        chk("invalid_rs_latched", RS_data_o, 32'hCAFE);
        chk("invalid_imm_latched", imm_o, 32'h00000042);
        chk("invalid_writereg", {27'd0, WriteReg_o}, 32'd3);
        chk("invalid_cnt_hold", {16'd0, bubble_cnt_o}, 32'd1);
        flush_i = 1'b1;
        step();
        step();
        chk("flush_on_bubble_cnt", {16'd0, bubble_cnt_o}, 32'd3);
        for (int i = 0; i < 65531; i++) step();
        chk("preload_fffe", {16'd0, bubble_cnt_o}, 32'hFFFE);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("saturate", {16'd0, bubble_cnt_o}, 32'hFFFF);
        end
        flush_i = 1'b0; valid_i = 1'b1; RS_data_i = 32'h55AA;
        step();
        chk("pre_areset_valid", {31'd0, valid_o}, 32'd1);
        chk("pre_areset_cnt", {16'd0, bubble_cnt_o}, 32'hFFFF);
        stall_i = 1'b1;
        #2 rst_i = 1'b0;
        #1;
        chk("areset_all_zero", all_or(), 32'd0);
        chk("areset_cnt", {16'd0, bubble_cnt_o}, 32'd0);
        #1 rst_i = 1'b1;
        stall_i = 1'b0;
        step();
        chk("post_reset_load_valid", {31'd0, valid_o}, 32'd1);
        chk("post_reset_load_rs", RS_data_o, 32'h55AA);
        chk("post_reset_cnt", {16'd0, bubble_cnt_o}, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
